plaintext_block_buffer: RTL and testbench

- Parametrised successor to the single-shot plaintext store. Accepts a plaintext byte stream over a valid/ready handshake and packs it into 64-byte ChaCha20 blocks.
- Holds up to NUM_BLOCKS blocks in a circular block buffer.
- Streams committed blocks to the keystream XOR stage one OUT_W-bit word per handshake.
- Partial final blocks are supported with per-byte keep masks and message-end marking.

---
 rtl/plaintext_block_buffer.sv | 128 ++++++++++++
 tb/tb_plaintext_block_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plaintext_block_buffer.sv
// Packs a plaintext byte stream into 64-byte ChaCha20 blocks held in a circular
// buffer, and streams committed blocks out as keep-masked words.
module plaintext_block_buffer #(
    parameter int unsigned BLOCK_BYTES = 64,
    parameter int unsigned NUM_BLOCKS  = 4,
    parameter int unsigned OUT_W       = 32,
    localparam int unsigned BPW    = OUT_W / 8,
    localparam int unsigned WPB    = BLOCK_BYTES / BPW,
    localparam int unsigned WIDX_W = (WPB > 1) ? $clog2(WPB) : 1,
    localparam int unsigned CNT_W  = $clog2(NUM_BLOCKS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_word,
    output logic [BPW-1:0]    out_keep,
    output logic [WIDX_W-1:0] out_widx,
    output logic              out_blk_last,
    output logic              out_msg_last,
    output logic [CNT_W-1:0]  blocks_avail,
    output logic              xor_ready
);

    localparam int unsigned PTR_W = $clog2(NUM_BLOCKS);
    localparam int unsigned OFF_W = $clog2(BLOCK_BYTES);
    localparam int unsigned LEN_W = OFF_W + 1;

    logic [7:0]       mem          [NUM_BLOCKS][BLOCK_BYTES];
    logic [LEN_W-1:0] blk_len      [NUM_BLOCKS];
    logic             blk_msg_last [NUM_BLOCKS];

    logic [PTR_W-1:0]  wr_blk;
    logic [OFF_W-1:0]  wr_off;
    logic [PTR_W-1:0]  rd_blk;
    logic [WIDX_W-1:0] rd_w;
    logic [CNT_W-1:0]  avail;

    logic             in_fire;
    logic             commit;
    logic             out_fire;
    logic             free_slot;
    logic             cur_blk_last;
    logic [LEN_W-1:0] cur_len;
    int unsigned      nwords;
    int unsigned      byte_idx;

    assign in_ready     = (avail < CNT_W'(NUM_BLOCKS));
    assign xor_ready    = (avail != '0);
    assign out_valid    = xor_ready;
    assign blocks_avail = avail;

    assign in_fire   = in_valid && in_ready;
    assign commit    = in_fire && (in_last || (wr_off == OFF_W'(BLOCK_BYTES - 1)));
    assign out_fire  = out_valid && out_ready;
    assign free_slot = out_fire && cur_blk_last;

    // Storage is never cleared; stale contents are hidden by len and out_valid.
    always_ff @(posedge clk) begin
        if (!rst && in_fire) begin
            mem[wr_blk][wr_off] <= in_byte;
            if (commit) begin
                blk_len[wr_blk]      <= LEN_W'(wr_off) + LEN_W'(1);
                blk_msg_last[wr_blk] <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_blk <= '0;
            wr_off <= '0;
            rd_blk <= '0;
            rd_w   <= '0;
            avail  <= '0;
        end else begin
            if (in_fire) begin
                wr_off <= commit ? '0 : wr_off + OFF_W'(1);
            end
            if (commit) begin
                wr_blk <= wr_blk + PTR_W'(1);
            end
            if (out_fire) begin
                if (cur_blk_last) begin
                    rd_w   <= '0;
                    rd_blk <= rd_blk + PTR_W'(1);
                end else begin
                    rd_w <= rd_w + WIDX_W'(1);
                end
            end
            case ({commit, free_slot})
                2'b10:   avail <= avail + CNT_W'(1);
                2'b01:   avail <= avail - CNT_W'(1);
                default: avail <= avail;
            endcase
        end
    end

    always_comb begin
        cur_len      = blk_len[rd_blk];
        nwords       = (32'(cur_len) + BPW - 1) / BPW;
        cur_blk_last = (32'(rd_w) == nwords - 1);
        byte_idx     = 0;
        out_word     = '0;
        out_keep     = '0;
        out_widx     = '0;
        out_blk_last = 1'b0;
        out_msg_last = 1'b0;
        if (out_valid) begin
            for (int unsigned i = 0; i < BPW; i++) begin
                byte_idx = 32'(rd_w) * BPW + i;
                // Lanes past the recorded length stay zero in both word and keep.
                if (byte_idx < 32'(cur_len)) begin
                    out_word[8*i +: 8] = mem[rd_blk][OFF_W'(byte_idx)];
                    out_keep[i]        = 1'b1;
                end
            end
            out_widx     = rd_w;
            out_blk_last = cur_blk_last;
            out_msg_last = cur_blk_last && blk_msg_last[rd_blk];
        end
    end

endmodule

// File: tb/tb_plaintext_block_buffer.sv
// Scoreboard bench for plaintext_block_buffer: a byte-level message model pushes
// expected output words; a negedge monitor compares every presented word.
module tb_plaintext_block_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [3:0]  out_keep;
    logic [3:0]  out_widx;
    logic        out_blk_last;
    logic        out_msg_last;
    logic [2:0]  blocks_avail;
    logic        xor_ready;

    plaintext_block_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_keep     (out_keep),
        .out_widx     (out_widx),
        .out_blk_last (out_blk_last),
        .out_msg_last (out_msg_last),
        .blocks_avail (blocks_avail),
        .xor_ready    (xor_ready)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  k;
        logic [3:0]  idx;
        logic        bl;
        logic        ml;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] cur[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         ready_mode = 0;
    int         stalls = 0;
    int         max_avail = 0;
    bit         track = 0;
    bit         bg_done = 0;
    logic       valid_at_accept = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a committed block of len bytes yields ceil(len/4) LE words.
    task automatic model_accept(input logic [7:0] b, input logic last);
        exp_t e;
        int   nw;
        cur.push_back(b);
        if (last || cur.size() == 64) begin
            nw = (cur.size() + 3) / 4;
            for (int k = 0; k < nw; k++) begin
                e     = '0;
                e.idx = 4'(k);
                for (int i = 0; i < 4; i++) begin
                    if (4 * k + i < cur.size()) begin
                        e.w[8*i +: 8] = cur[4*k + i];
                        e.k[i]        = 1'b1;
                    end
                end
                e.bl = (k == nw - 1);
                e.ml = e.bl && last;
                expq.push_back(e);
            end
            cur.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte has been accepted.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int   waited = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (!acc) begin
            @(negedge clk);
            acc             = in_ready;
            valid_at_accept = out_valid;
            if (acc) model_accept(b, last);
            else stalls++;
            @(posedge clk);
            #1;
            if (!acc && ++waited > 5000) begin
                chk("send_timeout", 64'(acc), 64'(1));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        ready_mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        expq.delete();
        cur.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        set_mode(1);
        while ((expq.size() != 0 || blocks_avail != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(t < 3000), 64'(1));
        chk("drain_avail", 64'(blocks_avail), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare the queue head whenever a word is presented, pop on transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (track && int'(blocks_avail) > max_avail) max_avail = int'(blocks_avail);
                if (out_valid) begin
                    if (expq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %0h expected no word", out_word);
                    end else begin
                        e = expq[0];
                        chk("out_beat",
                            64'({out_word, out_keep, out_widx, out_blk_last, out_msg_last}),
                            64'({e.w, e.k, e.idx, e.bl, e.ml}));
                        if (out_ready) void'(expq.pop_front());
                    end
                end else begin
                    chk("idle_outputs",
                        64'({out_word, out_keep, out_widx, out_blk_last, out_msg_last, xor_ready}),
                        64'(0));
                end
            end
        end
    end

    initial begin
        int t;
        int len;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        in_last  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_word", 64'(out_word), 64'(0));
        chk("reset_avail", 64'(blocks_avail), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        chk("reset_nothing_stored", 64'(blocks_avail), 64'(0));
        @(posedge clk);
        #1;

        // Full block 0x00..0x3F.
        set_mode(1);
        for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
        chk("valid_before_commit", 64'(valid_at_accept), 64'(0));
        chk("valid_after_commit", 64'(out_valid), 64'(1));
        drain();

        // Partial message of five bytes.
        for (int i = 0; i < 5; i++) send_byte(8'(8'h41 + i), i == 4);
        drain();

        // Fill all slots, hold an extra byte, then free one slot.
        reset_dut();
        set_mode(0);
        for (int i = 0; i < 256; i++) send_byte(8'($urandom), 1'b0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("full_avail", 64'(blocks_avail), 64'(4));
        bg_done = 0;
        fork
            begin
                send_byte(8'hC7, 1'b0);
                bg_done = 1;
            end
        join_none
        repeat (3) @(negedge clk);
        chk("held_in_ready", 64'(in_ready), 64'(0));
        chk("held_avail", 64'(blocks_avail), 64'(4));
        ready_mode = 1;
        repeat (16) @(negedge clk);
        ready_mode = 0;
        @(negedge clk);
        chk("freed_in_ready", 64'(in_ready), 64'(1));
        chk("freed_avail", 64'(blocks_avail), 64'(3));
        t = 0;
        while (!bg_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("held_byte_accepted", 64'(bg_done), 64'(1));
        @(posedge clk);
        #1;
        for (int i = 0; i < 63; i++) send_byte(8'($urandom), 1'b0);
        drain();

        // Continuous stream across slot wrap-around.
        set_mode(1);
        stalls    = 0;
        max_avail = 0;
        track     = 1;
        for (int i = 0; i < 640; i++) send_byte(8'($urandom), 1'b0);
        track = 0;
        chk("stream_stalls", 64'(stalls), 64'(0));
        chk("stream_max_avail_le1", 64'(max_avail <= 1), 64'(1));
        drain();

        // Reset with a committed block and a partial block in flight.
        set_mode(0);
        for (int i = 0; i < 94; i++) send_byte(8'($urandom), 1'b0);
        @(negedge clk);
        chk("midrst_avail_before", 64'(blocks_avail), 64'(1));
        @(posedge clk);
        #1;
        reset_dut();
        @(negedge clk);
        chk("midrst_avail", 64'(blocks_avail), 64'(0));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        set_mode(1);
        for (int i = 0; i < 64; i++) send_byte(8'(8'h80 + i), 1'b0);
        drain();

        // Random messages with random backpressure and gaps.
        set_mode(2);
        for (int m = 0; m < 25; m++) begin
            len = int'($urandom_range(1, 150));
            for (int i = 0; i < len; i++) begin
                send_byte(8'($urandom), i == len - 1);
                if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        end
        drain();
        chk("final_queue_empty", 64'(expq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
